// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor (refclk domain).
// Drives the PLL reset, qualifies the asynchronous locked flag, and keeps
// downstream logic in reset until lock has been stable for a settle period.
// A lock loss while running forces a full PLL relock.
// Optional status counters are built only when PLL_LOCK_STATUS_EN is defined;
// otherwise lock_loss_cnt/timeout_cnt read 0 and clear_cnt is ignored.
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_FILTER    = 64,
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned LOCK_TIMEOUT   = 10000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             clear_cnt,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    // Zero-length phases are stretched to one cycle.
    localparam int unsigned RST_EFF    = (PLL_RST_CYCLES == 0) ? 1 : PLL_RST_CYCLES;
    localparam int unsigned FILT_EFF   = (LOCK_FILTER    == 0) ? 1 : LOCK_FILTER;
    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES  == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned TMO_EFF    = (LOCK_TIMEOUT   == 0) ? 1 : LOCK_TIMEOUT;

    localparam int unsigned MAX_AB  = (RST_EFF > FILT_EFF) ? RST_EFF : FILT_EFF;
    localparam int unsigned PH_MAX  = (MAX_AB > SETTLE_EFF) ? MAX_AB : SETTLE_EFF;
    localparam int unsigned PH_W    = $clog2(PH_MAX + 1);
    localparam int unsigned TMO_W   = $clog2(TMO_EFF + 1);

    localparam logic [PH_W-1:0]  RST_LAST    = PH_W'(RST_EFF - 1);
    localparam logic [PH_W-1:0]  FILT_LAST   = PH_W'(FILT_EFF - 1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_EFF - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TMO_EFF - 1);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_SETTLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t           state_q, state_nxt;
    logic [PH_W-1:0]  phase_q, phase_nxt;
    logic [TMO_W-1:0] tmo_q, tmo_nxt;
    logic             sync1, lk_s;
    logic             loss_inc, tmo_inc;
    logic             pll_rst_nxt, sys_rst_nxt, ready_nxt;

    // Two-flop synchronizer for the asynchronous PLL locked flag.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1 <= 1'b0;
            lk_s  <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk_s  <= sync1;
        end
    end

    // State, phase/timeout counters and registered control outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= S_RESET_PLL;
            phase_q <= '0;
            tmo_q   <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            phase_q <= phase_nxt;
            tmo_q   <= tmo_nxt;
            pll_rst <= pll_rst_nxt;
            sys_rst <= sys_rst_nxt;
            ready   <= ready_nxt;
        end
    end

    // Next-state, counter and output decode; counters clear on any state change.
    always_comb begin
        state_nxt = state_q;
        phase_nxt = phase_q;
        tmo_nxt   = tmo_q;
        loss_inc  = 1'b0;
        tmo_inc   = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (phase_q == RST_LAST) state_nxt = S_WAIT_LOCK;
                else                     phase_nxt = phase_q + PH_W'(1);
            end
            S_WAIT_LOCK: begin
                tmo_nxt = tmo_q + TMO_W'(1);
                if (lk_s) begin
                    if (phase_q == FILT_LAST) state_nxt = S_SETTLE;
                    else                      phase_nxt = phase_q + PH_W'(1);
                end else begin
                    phase_nxt = '0;
                end
                // Lock completion takes priority over a coincident timeout.
                if (state_nxt == S_WAIT_LOCK && tmo_q == TMO_LAST) begin
                    state_nxt = S_RESET_PLL;
                    tmo_inc   = 1'b1;
                end
            end
            S_SETTLE: begin
                if (!lk_s)                       state_nxt = S_WAIT_LOCK;
                else if (phase_q == SETTLE_LAST) state_nxt = S_RUN;
                else                             phase_nxt = phase_q + PH_W'(1);
            end
            S_RUN: begin
                if (!lk_s) begin
                    state_nxt = S_RESET_PLL;
                    loss_inc  = 1'b1;
                end
            end
            default: state_nxt = S_RESET_PLL;
        endcase

        if (state_nxt != state_q) begin
            phase_nxt = '0;
            tmo_nxt   = '0;
        end

        pll_rst_nxt = (state_nxt == S_RESET_PLL);
        sys_rst_nxt = (state_nxt != S_RUN);
        ready_nxt   = (state_nxt == S_RUN);
    end

`ifdef PLL_LOCK_STATUS_EN
    // Saturating status counters; a clear overrides a coincident increment.
    always_ff @(posedge refclk) begin
        if (rst || clear_cnt) begin
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            if (loss_inc && lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
            if (tmo_inc  && timeout_cnt   != '1) timeout_cnt   <= timeout_cnt   + CNT_W'(1);
        end
    end
`else
    // Status counters not built: outputs read zero, event strobes are dropped.
    logic unused_status;
    assign unused_status = ^{clear_cnt, loss_inc, tmo_inc};
    assign lock_loss_cnt = '0;
    assign timeout_cnt   = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short phase lengths
// (reset 4, filter 8, settle 16, timeout 100, 8-bit counters).
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b1;
    logic       clear_cnt = 1'b0;
    logic       pll_rst, sys_rst, ready;
    logic [7:0] lock_loss_cnt, timeout_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(4),
        .LOCK_FILTER(8),
        .SETTLE_CYCLES(16),
        .LOCK_TIMEOUT(100),
        .CNT_W(8)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .clear_cnt(clear_cnt),
        .pll_rst(pll_rst),
        .sys_rst(sys_rst),
        .ready(ready),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_cnt(timeout_cnt)
    );

    always #5 refclk = ~refclk;

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Expected status counter value: saturating when built, zero otherwise.
    function automatic logic [7:0] ec(input int n);
`ifdef PLL_LOCK_STATUS_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    initial begin
        // Reset values
        step(2);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst", sys_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_loss", lock_loss_cnt, 0);
        chk("rst_tmo", timeout_cnt, 0);

        // Clean lock: rst released, last sampled high at edge 0
        rst = 1'b0;
        step(3);
        chk("clean_pll_rst_e3", pll_rst, 1);
        step(1);
        chk("clean_pll_rst_e4", pll_rst, 0);
        chk("clean_sys_rst_e4", sys_rst, 1);
        step(23);
        chk("clean_ready_e27", ready, 0);
        step(1);
        chk("clean_ready_e28", ready, 1);
        chk("clean_sys_rst_e28", sys_rst, 0);
        chk("clean_loss", lock_loss_cnt, 0);
        chk("clean_tmo", timeout_cnt, 0);

        // Lock loss in RUN: one-cycle drop, seen by the FSM two edges later
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        chk("loss_ready_e2", ready, 1);
        step(1);
        chk("loss_sys_rst", sys_rst, 1);
        chk("loss_ready", ready, 0);
        chk("loss_pll_rst", pll_rst, 1);
        chk("loss_cnt1", lock_loss_cnt, ec(1));
        step(27);
        chk("relock_ready_e30", ready, 0);
        step(1);
        chk("relock_ready_e31", ready, 1);

        // Filter glitch: 5 filtered highs, one low, then 8 highs before SETTLE
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        chk("glitch_loss_cnt2", lock_loss_cnt, ec(2));
        step(7);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(20);
        chk("glitch_ready_e31", ready, 0);
        step(5);
        chk("glitch_ready_e36", ready, 0);
        step(1);
        chk("glitch_ready_e37", ready, 1);
        chk("glitch_loss_same", lock_loss_cnt, ec(2));
        chk("glitch_tmo", timeout_cnt, 0);

        // Timeout retry: PLL never locks
        pll_locked = 1'b0;
        step(3);
        chk("tmo_loss_cnt3", lock_loss_cnt, ec(3));
        chk("tmo_pll_rst_e3", pll_rst, 1);
        step(4);
        chk("tmo_pll_rst_e7", pll_rst, 0);
        step(99);
        chk("tmo_pll_rst_e106", pll_rst, 0);
        chk("tmo_cnt0", timeout_cnt, 0);
        step(1);
        chk("tmo_pll_rst_e107", pll_rst, 1);
        chk("tmo_cnt1", timeout_cnt, ec(1));
        step(4);
        chk("tmo_pll_rst_e111", pll_rst, 0);
        step(100);
        chk("tmo_pll_rst_e211", pll_rst, 1);
        chk("tmo_cnt2", timeout_cnt, ec(2));
        step(104);
        chk("tmo_pll_rst_e315", pll_rst, 1);
        chk("tmo_cnt3", timeout_cnt, ec(3));
        pll_locked = 1'b1;
        step(27);
        chk("tmo_ready_e342", ready, 0);
        step(1);
        chk("tmo_ready_e343", ready, 1);
        chk("tmo_cnt3_hold", timeout_cnt, ec(3));

        // Saturation: 260 more lock losses with full relock each time
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            step(1);
            pll_locked = 1'b1;
            step(30);
        end
        chk("sat_loss_cnt", lock_loss_cnt, ec(263));
        chk("sat_ready", ready, 1);

        // Clear coinciding with a further lock loss
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        clear_cnt = 1'b1;
        step(1);
        clear_cnt = 1'b0;
        chk("clr_loss_cnt", lock_loss_cnt, 0);
        chk("clr_tmo_cnt", timeout_cnt, 0);
        chk("clr_ready", ready, 0);
        step(28);
        chk("clr_relock_ready", ready, 1);

        // Mid-operation reset during SETTLE
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        chk("mid_loss_cnt1", lock_loss_cnt, ec(1));
        step(14);
        chk("mid_settle_pll_rst", pll_rst, 0);
        chk("mid_settle_ready", ready, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_pll_rst", pll_rst, 1);
        chk("mid_sys_rst", sys_rst, 1);
        chk("mid_ready", ready, 0);
        chk("mid_loss_clr", lock_loss_cnt, 0);
        chk("mid_tmo_clr", timeout_cnt, 0);
        step(3);
        chk("mid_pll_rst_e3", pll_rst, 1);
        step(1);
        chk("mid_pll_rst_e4", pll_rst, 0);
        step(23);
        chk("mid_ready_e27", ready, 0);
        step(1);
        chk("mid_ready_e28", ready, 1);
        chk("mid_sys_rst_e28", sys_rst, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
